// File: rtl/ram_stream_reader_pkg.sv
// Shared types and sizing helpers for the channel-RAM stream reader.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FETCH = 2'd2,
    ST_SEND  = 2'd3
  } state_t;

  localparam int CNT_W = 16;

  function automatic int bytes_for(input int width);
    return (width + 7) / 8;
  endfunction

  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/ram_stream_reader_sample_serializer.sv
// Parallel sample word to MSB-byte-first byte stream with registered rdy/ack handshake.
module sample_serializer
  import ram_stream_reader_pkg::*;
#(
  parameter int BYTES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [BYTES*8-1:0] word,
  input  logic               tx_ack,
  output logic [7:0]         tx_data,
  output logic               tx_rdy,
  output logic               last_xfer
);

  localparam int IDX_W = idx_width(BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  logic [BYTES*8-1:0] shreg;
  logic [IDX_W-1:0]   byte_idx;
  logic               xfer;

  assign xfer      = tx_rdy && tx_ack;
  assign last_xfer = xfer && (byte_idx == LAST_IDX);
  assign tx_data   = shreg[BYTES*8-1 -: 8];

  // Register is cleared after the final byte so nothing lingers on tx_data when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      byte_idx <= '0;
      tx_rdy   <= 1'b0;
    end else if (load) begin
      shreg    <= word;
      byte_idx <= '0;
      tx_rdy   <= 1'b1;
    end else if (xfer) begin
      if (byte_idx == LAST_IDX) begin
        shreg    <= '0;
        byte_idx <= '0;
        tx_rdy   <= 1'b0;
      end else begin
        shreg    <= shreg << 8;
        byte_idx <= byte_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Requests a frame from the channel RAM controller and streams each sample out byte-wise.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int RAM_DATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [15:0]               n_samples_cfg,
  output logic                      rqst_buff,
  output logic [15:0]               n_samples,
  input  logic [RAM_DATA_WIDTH-1:0] data_in,
  input  logic                      data_rdy,
  input  logic                      data_eof,
  output logic                      data_ack,
  output logic [7:0]                tx_data,
  output logic                      tx_rdy,
  input  logic                      tx_ack,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int BYTES = bytes_for(RAM_DATA_WIDTH);

  state_t             state;
  logic [CNT_W-1:0]   sample_cnt;
  logic               first_seen;
  logic               abort;
  logic               load;
  logic               ser_last;
  logic [BYTES*8-1:0] word;

  assign word     = (BYTES*8)'(data_in);
  assign data_ack = (state == ST_FETCH) && data_rdy;
  // EOF is still asserted from the previous frame until the first sample arrives.
  assign abort    = (state == ST_FETCH) && data_eof && first_seen && (sample_cnt != '0);
  assign load     = data_ack && !abort;

  sample_serializer #(
    .BYTES(BYTES)
  ) u_serializer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .word     (word),
    .tx_ack   (tx_ack),
    .tx_data  (tx_data),
    .tx_rdy   (tx_rdy),
    .last_xfer(ser_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sample_cnt <= '0;
      first_seen <= 1'b0;
      n_samples  <= '0;
      rqst_buff  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      rqst_buff <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A zero length would make the RAM controller wrap to a full 65536-sample frame.
          if (start && (n_samples_cfg != '0)) begin
            n_samples  <= n_samples_cfg;
            sample_cnt <= n_samples_cfg;
            first_seen <= 1'b0;
            rqst_buff  <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (abort) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (data_rdy) begin
            sample_cnt <= sample_cnt - 16'd1;
            first_seen <= 1'b1;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (ser_last) begin
            if (sample_cnt == '0) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench: 8-bit and 10-bit readers against a behavioural channel RAM controller.
module tb_ram_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] cfg;

  logic        start8, rqst8, rdy8, eof8, ack8, txr8, txa8, busy8, done8, err8;
  logic [15:0] ns8;
  logic [7:0]  din8, txd8;

  logic        start10, rqst10, rdy10, eof10, ack10, txr10, txa10, busy10, done10, err10;
  logic [15:0] ns10;
  logic [9:0]  din10;
  logic [7:0]  txd10;

  ram_stream_reader #(.RAM_DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .n_samples_cfg(cfg), .rqst_buff(rqst8),
    .n_samples(ns8), .data_in(din8), .data_rdy(rdy8), .data_eof(eof8), .data_ack(ack8),
    .tx_data(txd8), .tx_rdy(txr8), .tx_ack(txa8), .busy(busy8), .done(done8), .err(err8)
  );

  ram_stream_reader #(.RAM_DATA_WIDTH(10)) dut10 (
    .clk(clk), .rst(rst), .start(start10), .n_samples_cfg(cfg), .rqst_buff(rqst10),
    .n_samples(ns10), .data_in(din10), .data_rdy(rdy10), .data_eof(eof10), .data_ack(ack10),
    .tx_data(txd10), .tx_rdy(txr10), .tx_ack(txa10), .busy(busy10), .done(done10), .err(err10)
  );

  // RAM controller model for dut8: mem[i] = 0x10+i, frame read from the top address down.
  logic [3:0] addr8;
  logic       dly8;
  int         cnt8;
  int         abort_after8;

  always @(posedge clk) begin
    if (rst) begin
      rdy8 <= 1'b0; eof8 <= 1'b1; dly8 <= 1'b0; addr8 <= 4'd0; din8 <= 8'h00; cnt8 <= 0;
    end else begin
      din8 <= 8'h10 + {4'h0, addr8};
      if (rqst8) begin
        addr8 <= 4'd15; dly8 <= 1'b1; cnt8 <= 0;
      end else if (dly8) begin
        dly8 <= 1'b0; rdy8 <= 1'b1; eof8 <= 1'b0;
      end
      if (ack8) begin
        addr8 <= addr8 - 4'd1;
        cnt8  <= cnt8 + 1;
        if (abort_after8 != 0 && cnt8 + 1 == abort_after8) begin
          rdy8 <= 1'b0; eof8 <= 1'b1;
        end
      end
      if (done8) begin
        rdy8 <= 1'b0; eof8 <= 1'b1;
      end
    end
  end

  logic dly10;
  assign din10 = 10'h2A5;
  always @(posedge clk) begin
    if (rst) begin
      rdy10 <= 1'b0; eof10 <= 1'b1; dly10 <= 1'b0;
    end else begin
      if (rqst10) dly10 <= 1'b1;
      else if (dly10) begin dly10 <= 1'b0; rdy10 <= 1'b1; eof10 <= 1'b0; end
      if (done10) begin rdy10 <= 1'b0; eof10 <= 1'b1; end
    end
  end

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  int acks, rqsts, dones, errs, stab, busy_cyc, ns_bad, post_acks;
  int rqst_cyc, ack_cyc, done_cyc;
  bit finished;
  logic busy_at_end;

  // Steps dut8 cycle by cycle and records what it did; the test tasks judge the record.
  task automatic run8(input int max_cycles, input bit do_start, input logic [15:0] n,
                      input bit rnd, input int tail, input bit poke);
    int end_at;
    logic prev_rdy, prev_ack;
    logic [7:0] prev_data;
    got_q.delete();
    acks = 0; rqsts = 0; dones = 0; errs = 0; stab = 0; busy_cyc = 0; ns_bad = 0;
    post_acks = 0; finished = 0; rqst_cyc = -1; ack_cyc = -1; done_cyc = -1;
    busy_at_end = 1'bx;
    prev_rdy = 1'b0; prev_ack = 1'b0; prev_data = 8'h00;
    end_at = max_cycles;
    for (int c = 0; c < end_at; c++) begin
      @(negedge clk);
      start8 = (do_start && c == 0) || (poke && c == 8);
      if (c == 0) cfg = n;
      else if (poke && c == 8) cfg = 16'd3;
      txa8 = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      if (prev_rdy && !prev_ack && (txr8 !== 1'b1 || txd8 !== prev_data)) stab++;
      if (finished) begin
        if (ack8) post_acks++;
      end else begin
        if (ack8) begin acks++; if (ack_cyc < 0) ack_cyc = c; end
        if (rqst8) begin rqsts++; if (rqst_cyc < 0) rqst_cyc = c; end
        if (busy8) begin busy_cyc++; if (ns8 !== n) ns_bad++; end
        if (txr8 && txa8) got_q.push_back(txd8);
        if (done8) dones++;
        if (err8) errs++;
        if (done8 || err8) begin
          finished = 1; done_cyc = c; busy_at_end = busy8; end_at = c + 1 + tail;
        end
      end
      prev_rdy = txr8; prev_ack = txa8; prev_data = txd8;
    end
    start8 = 1'b0;
    cfg = n;
  endtask

  task automatic test_reset();
    rst = 1'b1; start8 = 1'b0; start10 = 1'b0; cfg = 16'd0; txa8 = 1'b0; txa10 = 1'b0;
    abort_after8 = 0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (rqst8 !== 1'b0) $display("FAIL reset_rqst got %b expected 0", rqst8); else passes++;
    checks++; if (ns8 !== 16'd0) $display("FAIL reset_n_samples got %0d expected 0", ns8); else passes++;
    checks++; if (ack8 !== 1'b0) $display("FAIL reset_ack got %b expected 0", ack8); else passes++;
    checks++; if (txd8 !== 8'h00) $display("FAIL reset_tx_data got %02h expected 00", txd8); else passes++;
    checks++; if (txr8 !== 1'b0) $display("FAIL reset_tx_rdy got %b expected 0", txr8); else passes++;
    checks++; if (busy8 !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy8); else passes++;
    checks++; if (done8 !== 1'b0) $display("FAIL reset_done got %b expected 0", done8); else passes++;
    checks++; if (err8 !== 1'b0) $display("FAIL reset_err got %b expected 0", err8); else passes++;
    checks++; if (busy10 !== 1'b0 || txr10 !== 1'b0)
      $display("FAIL reset_dut10 got busy=%b tx_rdy=%b expected 0/0", busy10, txr10); else passes++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] e, g;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h1F - 8'(i));
    run8(200, 1, 16'd4, 0, 10, 0);
    checks++; if (!finished) $display("FAIL basic_timeout got no done expected done"); else passes++;
    checks++; if (got_q.size() != exp_q.size())
      $display("FAIL basic_count got %0d bytes expected %0d", got_q.size(), exp_q.size()); else passes++;
    for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL basic_byte%0d got %02h expected %02h", i, g, e); else passes++;
    end
    exp_q.delete();
    checks++; if (acks != 4) $display("FAIL basic_acks got %0d expected 4", acks); else passes++;
    checks++; if (dones != 1 || errs != 0)
      $display("FAIL basic_done got done=%0d err=%0d expected 1/0", dones, errs); else passes++;
    checks++; if (rqst_cyc != 1 || rqsts != 1)
      $display("FAIL basic_rqst got cycle %0d count %0d expected 1/1", rqst_cyc, rqsts); else passes++;
    checks++; if (ack_cyc != 3) $display("FAIL basic_first_ack got cycle %0d expected 3", ack_cyc); else passes++;
    checks++; if (done_cyc != 11) $display("FAIL basic_done_cycle got %0d expected 11", done_cyc); else passes++;
    checks++; if (busy_at_end !== 1'b0 || busy8 !== 1'b0)
      $display("FAIL basic_busy_after got %b/%b expected 0/0", busy_at_end, busy8); else passes++;
    checks++; if (ns_bad != 0 || busy_cyc != 10)
      $display("FAIL basic_busy_window got bad_n=%0d busy_cycles=%0d expected 0/10", ns_bad, busy_cyc); else passes++;
  endtask

  task automatic test_wide10();
    logic [7:0] e, g;
    int dn;
    bit fin;
    exp_q.push_back(8'h02); exp_q.push_back(8'hA5);
    got_q.delete(); dn = 0; fin = 0;
    for (int c = 0; c < 60 && !fin; c++) begin
      @(negedge clk);
      start10 = (c == 0);
      if (c == 0) cfg = 16'd1;
      txa10 = 1'b1;
      #1;
      if (txr10 && txa10) got_q.push_back(txd10);
      if (done10) begin dn++; fin = 1; end
    end
    start10 = 1'b0;
    checks++; if (got_q.size() != 2) $display("FAIL wide_count got %0d bytes expected 2", got_q.size()); else passes++;
    for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL wide_byte%0d got %02h expected %02h", i, g, e); else passes++;
    end
    exp_q.delete();
    checks++; if (dn != 1) $display("FAIL wide_done got %0d expected 1", dn); else passes++;
  endtask

  task automatic test_zero_cfg();
    run8(20, 1, 16'd0, 0, 0, 0);
    checks++; if (rqsts != 0) $display("FAIL zero_rqst got %0d expected 0", rqsts); else passes++;
    checks++; if (busy_cyc != 0 || finished)
      $display("FAIL zero_busy got busy_cycles=%0d finished=%0d expected 0/0", busy_cyc, finished); else passes++;
  endtask

  task automatic test_random_ack();
    logic [7:0] e, g;
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h1F - 8'(i));
    run8(600, 1, 16'd16, 1, 5, 1);
    checks++; if (!finished) $display("FAIL rand_timeout got no done expected done"); else passes++;
    checks++; if (got_q.size() != exp_q.size())
      $display("FAIL rand_count got %0d bytes expected %0d", got_q.size(), exp_q.size()); else passes++;
    for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL rand_byte%0d got %02h expected %02h", i, g, e); else passes++;
    end
    exp_q.delete();
    checks++; if (stab != 0) $display("FAIL rand_stable got %0d violations expected 0", stab); else passes++;
    checks++; if (acks != 16 || dones != 1)
      $display("FAIL rand_acks got acks=%0d done=%0d expected 16/1", acks, dones); else passes++;
    checks++; if (rqsts != 1 || ns_bad != 0)
      $display("FAIL rand_busy_start got rqsts=%0d bad_n=%0d expected 1/0", rqsts, ns_bad); else passes++;
  endtask

  task automatic test_abort();
    logic [7:0] e, g;
    abort_after8 = 2;
    exp_q.push_back(8'h1F); exp_q.push_back(8'h1E);
    run8(200, 1, 16'd5, 0, 20, 0);
    checks++; if (got_q.size() != 2) $display("FAIL abort_count got %0d bytes expected 2", got_q.size()); else passes++;
    for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL abort_byte%0d got %02h expected %02h", i, g, e); else passes++;
    end
    exp_q.delete();
    checks++; if (errs != 1 || dones != 0)
      $display("FAIL abort_err got err=%0d done=%0d expected 1/0", errs, dones); else passes++;
    checks++; if (acks != 2 || post_acks != 0)
      $display("FAIL abort_acks got %0d+%0d expected 2+0", acks, post_acks); else passes++;
    checks++; if (busy_at_end !== 1'b0 || busy8 !== 1'b0 || txr8 !== 1'b0)
      $display("FAIL abort_idle got busy=%b/%b tx_rdy=%b expected 0/0/0", busy_at_end, busy8, txr8); else passes++;
    abort_after8 = 0;
  endtask

  task automatic test_mid_reset();
    logic [7:0] e, g;
    run8(9, 1, 16'd5, 0, 0, 0);
    checks++; if (txr8 !== 1'b1 || acks != 3)
      $display("FAIL midrst_pre got tx_rdy=%b acks=%0d expected 1/3", txr8, acks); else passes++;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if ({rqst8, ack8, txr8, busy8, done8, err8} !== 6'b0 || txd8 !== 8'h00 || ns8 !== 16'd0)
      $display("FAIL midrst_outputs got flags=%b tx_data=%02h n=%0d expected 000000/00/0",
               {rqst8, ack8, txr8, busy8, done8, err8}, txd8, ns8); else passes++;
    rst = 1'b0;
    exp_q.push_back(8'h1F); exp_q.push_back(8'h1E);
    run8(100, 1, 16'd2, 0, 5, 0);
    checks++; if (got_q.size() != 2 || acks != 2 || dones != 1)
      $display("FAIL midrst_frame got bytes=%0d acks=%0d done=%0d expected 2/2/1",
               got_q.size(), acks, dones); else passes++;
    for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) $display("FAIL midrst_byte%0d got %02h expected %02h", i, g, e); else passes++;
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wide10();
    test_zero_cfg();
    test_random_ack();
    test_abort();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
